// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared states, score thresholds and card-value helper for the baccarat dealer
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_DECIDE,
        S_P3,
        S_BANK,
        S_D3,
        S_RESULT,
        S_DONE
    } deal_state_e;

    localparam logic [3:0] SCORE_NATURAL = 4'd8;
    localparam logic [3:0] PLAYER_STAND  = 4'd6;
    localparam logic [3:0] FACE_MIN      = 4'd10;

    // Tens and face cards count as zero; rank 0 (no card) is already zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= FACE_MIN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/deal_sequencer_banker_rule.sv
// rtl/deal_sequencer_banker_rule.sv - banker third-card draw table
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    assign v = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - baccarat deal FSM: card load strobes, third-card decisions, result lights
module deal_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    deal_state_e state_q, state_d;
    logic        player_light_q, player_light_d;
    logic        dealer_light_q, dealer_light_d;
    logic        bank_draw;
    logic        natural;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (bank_draw)
    );

    assign natural          = (pscore >= SCORE_NATURAL) || (dscore >= SCORE_NATURAL);
    assign player_win_light = player_light_q;
    assign dealer_win_light = dealer_light_q;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= S_P1;
            player_light_q <= 1'b0;
            dealer_light_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_light_q <= player_light_d;
            dealer_light_q <= dealer_light_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        player_light_d = player_light_q;
        dealer_light_d = dealer_light_q;
        if (step) begin
            case (state_q)
                S_P1:     state_d = S_D1;
                S_D1:     state_d = S_P2;
                S_P2:     state_d = S_D2;
                S_D2:     state_d = S_DECIDE;
                S_DECIDE: begin
                    if (natural)                    state_d = S_RESULT;
                    else if (pscore < PLAYER_STAND) state_d = S_P3;
                    else if (dscore < PLAYER_STAND) state_d = S_D3;
                    else                            state_d = S_RESULT;
                end
                S_P3:     state_d = S_BANK;
                S_BANK:   state_d = bank_draw ? S_D3 : S_RESULT;
                S_D3:     state_d = S_RESULT;
                S_RESULT: begin
                    // A tie lights both lamps.
                    player_light_d = (pscore >= dscore);
                    dealer_light_d = (dscore >= pscore);
                    state_d        = S_DONE;
                end
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_P1;
            endcase
        end
    end

    // Strobes are gated by resetb so none escape while reset is held.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        if (step && resetb) begin
            case (state_q)
                S_P1:    load_pcard1 = 1'b1;
                S_D1:    load_dcard1 = 1'b1;
                S_P2:    load_pcard2 = 1'b1;
                S_D2:    load_dcard2 = 1'b1;
                S_P3:    load_pcard3 = 1'b1;
                S_D3:    load_dcard3 = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deal_sequencer.sv
// tb/tb_deal_sequencer.sv - self-checking bench for deal_sequencer with baccarat reference model
module tb_deal_sequencer;

    logic       clk = 1'b0;
    logic       resetb;
    logic       step;
    logic [3:0] pscore, dscore, pcard3;
    logic       lp1, lp2, lp3, ld1, ld2, ld3;
    logic       pwl, dwl;
    logic [5:0] loads;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         check_en = 1'b0;
    logic [5:0] exp_load = '0;
    logic       exp_pl   = 1'b0;
    logic       exp_dl   = 1'b0;

    // mask bits: 0=P1 1=D1 2=P2 3=D2 4=P3 5=D3
    assign loads = {ld3, lp3, ld2, lp2, ld1, lp1};

    always #5 clk = ~clk;

    deal_sequencer dut (
        .slow_clock       (clk),
        .resetb           (resetb),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (lp1),
        .load_pcard2      (lp2),
        .load_pcard3      (lp3),
        .load_dcard1      (ld1),
        .load_dcard2      (ld2),
        .load_dcard3      (ld3),
        .player_win_light (pwl),
        .dealer_win_light (dwl)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("rand_loads", {2'b0, loads}, {2'b0, exp_load});
            check("rand_player_light", {7'b0, pwl}, {7'b0, exp_pl});
            check("rand_dealer_light", {7'b0, dwl}, {7'b0, exp_dl});
        end
    end

    // Banker draws when the player's third-card value is in the set for its score.
    function automatic bit model_bank_draw(input int ds, input int pc);
        logic [9:0] allowed [10];
        int v;
        allowed = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
                    10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
        v = (pc >= 1 && pc <= 9) ? pc : 0;
        return allowed[ds][v];
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetb = 1'b0;
        step   = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;
    endtask

    task automatic dstep(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc,
                         output logic [5:0] m);
        @(posedge clk);
        #1;
        step = 1'b1; pscore = ps; dscore = ds; pcard3 = pc;
        @(negedge clk);
        m = loads;
    endtask

    task automatic deal4(input string nm);
        logic [5:0] m;
        dstep(4'd0, 4'd0, 4'd0, m); check({nm, "_p1"}, {2'b0, m}, 8'h01);
        dstep(4'd0, 4'd0, 4'd0, m); check({nm, "_d1"}, {2'b0, m}, 8'h02);
        dstep(4'd0, 4'd0, 4'd0, m); check({nm, "_p2"}, {2'b0, m}, 8'h04);
        dstep(4'd0, 4'd0, 4'd0, m); check({nm, "_d2"}, {2'b0, m}, 8'h08);
    endtask

    task automatic rand_hand();
        int   plan[$];
        int   tail, it, ps, ds, pc;
        bit   st, pend, npl, ndl;
        check_en = 1'b0;
        do_reset();
        plan = '{1, 2, 4, 8, -1};
        exp_pl = 1'b0; exp_dl = 1'b0; exp_load = '0;
        tail = 0; pend = 1'b0; npl = 1'b0; ndl = 1'b0;
        check_en = 1'b1;
        while (tail < 4) begin
            @(posedge clk);
            #1;
            if (pend) begin
                exp_pl = npl; exp_dl = ndl; pend = 1'b0;
            end
            st = ($urandom_range(0, 3) != 0);
            ps = $urandom_range(0, 9);
            ds = $urandom_range(0, 9);
            pc = $urandom_range(0, 13);
            step = st; pscore = 4'(ps); dscore = 4'(ds); pcard3 = 4'(pc);
            exp_load = '0;
            if (plan.size() == 0) begin
                tail++;
            end else if (st) begin
                it = plan.pop_front();
                if (it > 0) exp_load = it[5:0];
                else if (it == -1) begin
                    if (ps >= 8 || ds >= 8)  plan.push_back(-3);
                    else if (ps <= 5)        begin plan.push_back(16); plan.push_back(-2); end
                    else if (ds <= 5)        begin plan.push_back(32); plan.push_back(-3); end
                    else                     plan.push_back(-3);
                end else if (it == -2) begin
                    if (model_bank_draw(ds, pc)) plan.push_back(32);
                    plan.push_back(-3);
                end else begin
                    npl = (ps >= ds); ndl = (ds >= ps); pend = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] m;
        resetb = 1'b0; step = 1'b1; pscore = '0; dscore = '0; pcard3 = '0;
        #3;
        check("reset_loads", {2'b0, loads}, 8'h00);
        check("reset_lights", {6'b0, pwl, dwl}, 8'h00);
        @(posedge clk);
        #1;
        resetb = 1'b1; step = 1'b0;

        // Natural 8 for the player
        deal4("nat");
        dstep(4'd8, 4'd3, 4'd0, m); check("nat_decide", {2'b0, m}, 8'h00);
        dstep(4'd8, 4'd3, 4'd0, m); check("nat_result", {2'b0, m}, 8'h00);
        dstep(4'd8, 4'd3, 4'd0, m); check("nat_done", {2'b0, m}, 8'h00);
        check("nat_lights", {6'b0, pwl, dwl}, 8'h02);

        // Banker on 3 stands against an 8
        do_reset(); deal4("b8");
        dstep(4'd4, 4'd3, 4'd0, m); check("b8_decide", {2'b0, m}, 8'h00);
        dstep(4'd4, 4'd3, 4'd0, m); check("b8_p3", {2'b0, m}, 8'h10);
        dstep(4'd2, 4'd3, 4'd8, m); check("b8_bank", {2'b0, m}, 8'h00);
        dstep(4'd2, 4'd3, 4'd8, m); check("b8_result", {2'b0, m}, 8'h00);
        dstep(4'd2, 4'd3, 4'd8, m); check("b8_done", {2'b0, m}, 8'h00);
        check("b8_lights", {6'b0, pwl, dwl}, 8'h01);

        // Face third card counts zero: banker on 3 draws, strobe lasts one cycle
        do_reset(); deal4("face");
        dstep(4'd4, 4'd3, 4'd0, m);
        dstep(4'd4, 4'd3, 4'd0, m);
        dstep(4'd2, 4'd3, 4'd12, m); check("face_bank", {2'b0, m}, 8'h00);
        dstep(4'd2, 4'd3, 4'd12, m); check("face_d3", {2'b0, m}, 8'h20);
        dstep(4'd2, 4'd3, 4'd12, m); check("face_d3_once", {2'b0, m}, 8'h00);

        // Banker on 6 stands against a 5
        do_reset(); deal4("b6");
        dstep(4'd3, 4'd6, 4'd0, m);
        dstep(4'd3, 4'd6, 4'd0, m); check("b6_p3", {2'b0, m}, 8'h10);
        dstep(4'd3, 4'd6, 4'd5, m);
        dstep(4'd3, 4'd6, 4'd5, m); check("b6_result", {2'b0, m}, 8'h00);
        dstep(4'd3, 4'd6, 4'd5, m); check("b6_lights", {6'b0, pwl, dwl}, 8'h01);

        // Player stands on 6, banker draws from 4, ends in a tie
        do_reset(); deal4("tie");
        dstep(4'd6, 4'd4, 4'd0, m); check("tie_decide", {2'b0, m}, 8'h00);
        dstep(4'd6, 4'd4, 4'd0, m); check("tie_d3", {2'b0, m}, 8'h20);
        dstep(4'd6, 4'd6, 4'd0, m); check("tie_result", {2'b0, m}, 8'h00);
        dstep(4'd1, 4'd9, 4'd0, m); check("tie_lights", {6'b0, pwl, dwl}, 8'h03);
        @(posedge clk);
        #3;
        resetb = 1'b0;
        #1;
        check("done_async_reset_lights", {6'b0, pwl, dwl}, 8'h00);
        @(posedge clk);
        #1;
        resetb = 1'b1; step = 1'b0;

        // Step gating in S_P2
        dstep(4'd0, 4'd0, 4'd0, m); check("gate_p1", {2'b0, m}, 8'h01);
        dstep(4'd0, 4'd0, 4'd0, m); check("gate_d1", {2'b0, m}, 8'h02);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            step = 1'b0;
            @(negedge clk);
            check("gate_idle", {2'b0, loads}, 8'h00);
        end
        dstep(4'd0, 4'd0, 4'd0, m); check("gate_p2", {2'b0, m}, 8'h04);
        dstep(4'd0, 4'd0, 4'd0, m); check("gate_d2", {2'b0, m}, 8'h08);

        // Async reset while sitting in S_D3
        do_reset(); deal4("ar");
        dstep(4'd4, 4'd3, 4'd0, m);
        dstep(4'd4, 4'd3, 4'd0, m);
        dstep(4'd2, 4'd3, 4'd12, m);
        dstep(4'd2, 4'd3, 4'd12, m); check("ar_in_d3", {2'b0, m}, 8'h20);
        #2;
        resetb = 1'b0;
        #1;
        check("ar_loads", {2'b0, loads}, 8'h00);
        check("ar_lights", {6'b0, pwl, dwl}, 8'h00);
        @(posedge clk);
        #1;
        resetb = 1'b1; step = 1'b0;
        dstep(4'd0, 4'd0, 4'd0, m); check("ar_first_p1", {2'b0, m}, 8'h01);

        for (int h = 0; h < 200; h++) rand_hand();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 slow_clock  input  1  single clock; all state changes on its rising edge.
REQ-002 resetb  input  1  reset, asynchronous, active-low.
REQ-003 step  input  1  advance enable; the FSM moves only in cycles where step=1.
REQ-004 pscore  input  4  player hand score, 0..9, from the combinational scorer.
REQ-005 dscore  input  4  dealer hand score, 0..9, from the combinational scorer.
REQ-006 pcard3  input  4  player third-card rank: 1=Ace..13=King; 0 = no card.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  card-register load strobes, player.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  card-register load strobes, dealer.
REQ-009 player_win_light, dealer_win_light  output  1 each  result lights.

Function
REQ-010 States SHALL be: S_P1, S_D1, S_P2, S_D2, S_DECIDE, S_P3, S_BANK, S_D3, S_RESULT, S_DONE.
REQ-011 load_X SHALL be (state==S_X) AND step; at most one load strobe high per cycle; none high in any other state.
REQ-012 With step=0, state and all outputs SHALL hold unchanged.
REQ-013 Deal order on step: S_P1->S_D1->S_P2->S_D2->S_DECIDE, one card per step cycle.
REQ-014 Scores are valid one cycle after a load edge; decision states SHALL sample pscore/dscore/pcard3 only on their own step cycle.
REQ-015 S_DECIDE: pscore>=8 or dscore>=8 (natural) -> S_RESULT; else pscore<=5 -> S_P3; else (player 6/7) dscore<=5 -> S_D3, dscore>=6 -> S_RESULT.
REQ-016 S_P3 -> S_BANK on step.
REQ-017 S_BANK: third-card value v = pcard3 if 1..9, else 0 (ranks 10..13 and 0 give 0).
REQ-018 S_BANK draws (-> S_D3) when: dscore<=2; dscore=3 and v!=8; dscore=4 and v in 2..7; dscore=5 and v in 4..7; dscore=6 and v in 6..7; otherwise (incl. dscore=7) -> S_RESULT.
REQ-019 S_D3 -> S_RESULT on step.
REQ-020 S_RESULT on step: register player_win_light = (pscore>dscore) OR tie, dealer_win_light = (dscore>pscore) OR tie; -> S_DONE.
REQ-021 Score comparison SHALL be 4-bit unsigned; inputs >9 are out of contract, no checking.
REQ-022 S_DONE SHALL be absorbing; lights held; no loads until reset.
REQ-023 Lights SHALL be 0 in every state except S_DONE.

Reset
REQ-024 resetb=0 SHALL immediately, independent of slow_clock, force state S_P1 and clear lights; load strobes are 0 while resetb=0 regardless of step.
REQ-025 Reset asserted mid-hand SHALL abandon the hand; first step after release strobes load_pcard1.

Structure
REQ-026 Shared package baccarat_pkg SHALL hold the state enum and constants (SCORE_NATURAL=8, PLAYER_STAND=6, FACE_MIN=10).
REQ-027 Banker third-card table (REQ-017/018) SHALL be a separate combinational sub-module banker_rule (inputs dscore, pcard3; output draw).
REQ-028 State register and light registers only; all else combinational; target 150-250 lines.

Verification
REQ-029 Natural: after S_D2 pscore=8, dscore=3, step each cycle -> no load_pcard3/load_dcard3 ever; in S_DONE player_win_light=1, dealer_win_light=0.
REQ-030 Banker stands on 8: pscore=4 -> load_pcard3; then pcard3=8, pscore=2, dscore=3 -> no load_dcard3; S_DONE dealer=1, player=0.
REQ-031 Face third card: pcard3=12, dscore=3 -> load_dcard3 pulsed exactly one cycle; pcard3=5, dscore=6 -> no draw.
REQ-032 Player stands, tie: pscore=6, dscore=4 -> load_dcard3; then dscore=6 -> both lights 1.
REQ-033 step gating: hold step=0 for 5 cycles in S_P2 -> no strobes, state unchanged; step=1 -> one load_pcard2 pulse.
REQ-034 Async reset in S_D3 between clock edges -> lights and strobes 0 at once; state S_P1; next step strobes load_pcard1.
